// File: rtl/fighter_anim_seq.sv
// Animation sequencer for one fighter sprite: picks which pose of the packed
// sprite-ROM pixels reaches the colour mapper. Handles idle breathe (with
// health-based rage), multi-frame walk, one-shot attack and hit-stun, all
// stepped by a synchronised per-frame tick.
module fighter_anim_seq #(
  parameter int COLOR_W       = 4,
  parameter int WALK_FRAMES   = 2,
  parameter int WALK_PERIOD   = 6,
  parameter int BREATHE_HALF  = 13,
  parameter int ATTACK_FRAMES = 3,
  parameter int ATTACK_PERIOD = 4,
  parameter int HIT_TICKS     = 8,
  parameter int RAGE_THRESH   = 120,
  localparam int NUM_SPRITES  = 4 + WALK_FRAMES + ATTACK_FRAMES,
  localparam int SEL_W        = $clog2(NUM_SPRITES)
) (
  input  logic                               vga_clk,
  input  logic                               reset_n,
  input  logic                               vsync,
  input  logic [9:0]                         motionx1,
  input  logic [7:0]                         healthL,
  input  logic                               attack_req,
  input  logic                               hit_req,
  input  logic [NUM_SPRITES*3*COLOR_W-1:0]   rgb_in,
  output logic [COLOR_W-1:0]                 red,
  output logic [COLOR_W-1:0]                 green,
  output logic [COLOR_W-1:0]                 blue,
  output logic [SEL_W-1:0]                   sprite_sel,
  output logic [1:0]                         anim_state,
  output logic                               busy
);

  localparam int PIX_W = 3 * COLOR_W;
  localparam int BR_W  = $clog2(2 * BREATHE_HALF);
  localparam int WP_W  = $clog2(WALK_PERIOD + 1);
  localparam int WF_W  = $clog2(WALK_FRAMES + 1);
  localparam int AP_W  = $clog2(ATTACK_PERIOD + 1);
  localparam int AF_W  = $clog2(ATTACK_FRAMES + 1);
  localparam int HT_W  = $clog2(HIT_TICKS + 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StWalk   = 2'd1;
  localparam logic [1:0] StAttack = 2'd2;
  localparam logic [1:0] StHit    = 2'd3;

  localparam logic [BR_W-1:0] BrLast = BR_W'(2 * BREATHE_HALF - 1);
  localparam logic [WP_W-1:0] WpLast = WP_W'(WALK_PERIOD - 1);
  localparam logic [WF_W-1:0] WfLast = WF_W'(WALK_FRAMES - 1);
  localparam logic [AP_W-1:0] ApLast = AP_W'(ATTACK_PERIOD - 1);
  localparam logic [AF_W-1:0] AfLast = AF_W'(ATTACK_FRAMES - 1);
  localparam logic [HT_W-1:0] HtLast = HT_W'(HIT_TICKS - 1);

  logic vs_meta, vs_sync, vs_prev, tick;
  logic att_pend, hit_pend, att_now, hit_now;

  logic [1:0]      state_q, state_d;
  logic [BR_W-1:0] br_q, br_d;
  logic [WP_W-1:0] wp_q, wp_d;
  logic [WF_W-1:0] wf_q, wf_d;
  logic [AP_W-1:0] ap_q, ap_d;
  logic [AF_W-1:0] af_q, af_d;
  logic [HT_W-1:0] ht_q, ht_d;
  logic            leave;
  logic [SEL_W-1:0] pose_d;
  logic [PIX_W-1:0] pix;

  // vsync synchroniser and edge detect. Flops reset high so a vsync that is
  // already high when reset releases is not mistaken for a rising edge.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_meta <= 1'b1;
      vs_sync <= 1'b1;
      vs_prev <= 1'b1;
    end else begin
      vs_meta <= vsync;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
    end
  end

  assign tick = vs_sync & ~vs_prev;

  // A request arriving on the tick cycle itself is consumed by that tick.
  assign att_now = att_pend | attack_req;
  assign hit_now = hit_pend | hit_req;

  // Sticky request flags, cleared by every tick.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      att_pend <= 1'b0;
      hit_pend <= 1'b0;
    end else if (tick) begin
      att_pend <= 1'b0;
      hit_pend <= 1'b0;
    end else begin
      if (attack_req) att_pend <= 1'b1;
      if (hit_req)    hit_pend <= 1'b1;
    end
  end

  // Next state and counters; everything holds unless this is a tick cycle.
  always_comb begin
    state_d = state_q;
    br_d    = br_q;
    wp_d    = wp_q;
    wf_d    = wf_q;
    ap_d    = ap_q;
    af_d    = af_q;
    ht_d    = ht_q;
    leave   = 1'b0;
    if (tick) begin
      if (hit_now) begin
        state_d = StHit;
        ht_d    = '0;
      end else if (att_now && (state_q == StIdle || state_q == StWalk)) begin
        state_d = StAttack;
        ap_d    = '0;
        af_d    = '0;
      end else begin
        case (state_q)
          StIdle: begin
            if (motionx1 != 10'd0) begin
              state_d = StWalk;
              wp_d    = '0;
              wf_d    = '0;
            end else begin
              br_d = (br_q == BrLast) ? '0 : br_q + 1'b1;
            end
          end
          StWalk: begin
            if (motionx1 == 10'd0) begin
              state_d = StIdle;
              br_d    = '0;
            end else if (wp_q == WpLast) begin
              wp_d = '0;
              wf_d = (wf_q == WfLast) ? '0 : wf_q + 1'b1;
            end else begin
              wp_d = wp_q + 1'b1;
            end
          end
          StAttack: begin
            if (ap_q == ApLast) begin
              ap_d = '0;
              if (af_q == AfLast) leave = 1'b1;
              else                af_d  = af_q + 1'b1;
            end else begin
              ap_d = ap_q + 1'b1;
            end
          end
          default: begin
            if (ht_q == HtLast) leave = 1'b1;
            else                ht_d  = ht_q + 1'b1;
          end
        endcase
        if (leave) begin
          if (motionx1 != 10'd0) begin
            state_d = StWalk;
            wp_d    = '0;
            wf_d    = '0;
          end else begin
            state_d = StIdle;
            br_d    = '0;
          end
        end
      end
    end
  end

  // Pose for the state/counters about to be registered.
  always_comb begin
    pose_d = '0;
    case (state_d)
      StIdle: begin
        if (int'(br_d) >= BREATHE_HALF)        pose_d = SEL_W'(2);
        else if (int'(healthL) >= RAGE_THRESH) pose_d = SEL_W'(1);
        else                                   pose_d = '0;
      end
      StWalk:   pose_d = SEL_W'(3) + SEL_W'(wf_d);
      StAttack: pose_d = SEL_W'(3 + WALK_FRAMES) + SEL_W'(af_d);
      default:  pose_d = SEL_W'(NUM_SPRITES - 1);
    endcase
  end

  // State, counters and registered outputs, advanced only on tick.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      br_q       <= '0;
      wp_q       <= '0;
      wf_q       <= '0;
      ap_q       <= '0;
      af_q       <= '0;
      ht_q       <= '0;
      sprite_sel <= '0;
      busy       <= 1'b0;
    end else if (tick) begin
      state_q    <= state_d;
      br_q       <= br_d;
      wp_q       <= wp_d;
      wf_q       <= wf_d;
      ap_q       <= ap_d;
      af_q       <= af_d;
      ht_q       <= ht_d;
      sprite_sel <= pose_d;
      busy       <= (state_d == StAttack) || (state_d == StHit);
    end
  end

  assign anim_state = state_q;

  // Zero-latency pixel mux; out-of-range selects fall back to pose 0.
  always_comb begin
    pix = rgb_in[PIX_W-1:0];
    for (int k = 0; k < NUM_SPRITES; k++) begin
      if (sprite_sel == SEL_W'(k)) pix = rgb_in[k*PIX_W +: PIX_W];
    end
  end

  assign {red, green, blue} = pix;

endmodule

// File: tb/tb_fighter_anim_seq.sv
// Scoreboard bench for fighter_anim_seq: the driver pushes the expected pose,
// state and busy for every frame tick it issues; a monitor samples the DUT a
// few cycles after each vsync rise (or an explicit probe) and compares.
module tb_fighter_anim_seq;

  localparam int NS = 9;
  localparam int SW = 4;

  typedef struct packed {
    logic [SW-1:0] sel;
    logic [1:0]    st;
    logic          bsy;
  } exp_t;

  logic            vga_clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            vsync = 1'b0;
  logic [9:0]      motionx1 = 10'd5;
  logic [7:0]      healthL = 8'd100;
  logic            attack_req = 1'b0;
  logic            hit_req = 1'b0;
  logic [NS*12-1:0] rgb_in;
  logic [3:0]      red, green, blue;
  logic [SW-1:0]   sprite_sel;
  logic [1:0]      anim_state;
  logic            busy;

  logic probe = 1'b0;
  logic mon_en = 1'b0;
  exp_t sb_q[$];
  int   n_checks = 0;
  int   pass_cnt = 0;
  int   n_samples = 0;

  fighter_anim_seq dut (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .vsync      (vsync),
    .motionx1   (motionx1),
    .healthL    (healthL),
    .attack_req (attack_req),
    .hit_req    (hit_req),
    .rgb_in     (rgb_in),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .sprite_sel (sprite_sel),
    .anim_state (anim_state),
    .busy       (busy)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic logic [11:0] pix_of(input int k);
    return 12'(k * 12'h111 + 12'h0A5);
  endfunction

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    n_checks++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s sample %0d: got %0d expected %0d", nm, idx, act, exp);
  endtask

  // Monitor: one sample per vsync rise (when enabled) or per probe pulse.
  initial begin
    exp_t e;
    forever begin
      @(posedge vsync or posedge probe);
      if (probe || mon_en) begin
        repeat (5) @(negedge vga_clk);
        n_samples++;
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL underflow sample %0d: got no expected entry", n_samples);
        end else begin
          e = sb_q.pop_front();
          chk("sprite_sel", n_samples, int'(sprite_sel), int'(e.sel));
          chk("anim_state", n_samples, int'(anim_state), int'(e.st));
          chk("busy", n_samples, int'(busy), int'(e.bsy));
          chk("rgb", n_samples, int'({red, green, blue}), int'(pix_of(int'(e.sel))));
        end
      end
    end
  end

  task automatic push(input int sel, input int st, input int bsy);
    exp_t e;
    e.sel = SW'(sel);
    e.st  = 2'(st);
    e.bsy = bsy[0];
    sb_q.push_back(e);
  endtask

  task automatic vs_pulse();
    @(negedge vga_clk) vsync = 1'b1;
    repeat (3) @(negedge vga_clk);
    vsync = 1'b0;
    repeat (7) @(negedge vga_clk);
  endtask

  // n ticks, each expected to show the given pose/state/busy afterwards.
  task automatic tk(input int sel, input int st, input int bsy, input int n);
    for (int i = 0; i < n; i++) begin
      push(sel, st, bsy);
      vs_pulse();
    end
  endtask

  task automatic do_probe(input int sel, input int st, input int bsy);
    push(sel, st, bsy);
    @(negedge vga_clk) probe = 1'b1;
    @(negedge vga_clk) probe = 1'b0;
    repeat (6) @(negedge vga_clk);
  endtask

  task automatic pulse_req(input logic a, input logic h);
    @(negedge vga_clk);
    attack_req = a;
    hit_req    = h;
    @(negedge vga_clk);
    attack_req = 1'b0;
    hit_req    = 1'b0;
    repeat (2) @(negedge vga_clk);
  endtask

  initial begin
    for (int k = 0; k < NS; k++) rgb_in[k*12 +: 12] = pix_of(k);
    #2 reset_n = 1'b0;
    // Reset held mid-frame with motion and vsync activity.
    repeat (2) vs_pulse();
    @(negedge vga_clk) vsync = 1'b1;
    repeat (3) @(negedge vga_clk);
    do_probe(0, 0, 0);
    // Release with vsync still high and motion nonzero: no tick may occur.
    @(negedge vga_clk) reset_n = 1'b1;
    repeat (10) @(negedge vga_clk);
    do_probe(0, 0, 0);
    motionx1 = 10'd0;
    @(negedge vga_clk) vsync = 1'b0;
    repeat (6) @(negedge vga_clk);
    mon_en = 1'b1;

    // Idle breathe: reset slot plus 12 ticks of stand, 13 of breathe, wrap.
    tk(0, 0, 0, 12);
    tk(2, 0, 0, 13);
    tk(0, 0, 0, 3);
    // Rage stand while health is high, normal stand once it drops.
    healthL = 8'd130;
    tk(1, 0, 0, 3);
    healthL = 8'd100;
    tk(0, 0, 0, 1);
    // Walk: 6 ticks per frame, two frames, wrap.
    motionx1 = 10'd3;
    tk(3, 1, 0, 6);
    tk(4, 1, 0, 6);
    tk(3, 1, 0, 1);
    // Back to idle, breathe counter restarts at 0.
    motionx1 = 10'd0;
    tk(0, 0, 0, 13);
    tk(2, 0, 0, 1);
    // Attack from walk; a second request mid-attack is ignored.
    motionx1 = 10'd3;
    tk(3, 1, 0, 2);
    pulse_req(1'b1, 1'b0);
    tk(5, 2, 1, 4);
    tk(6, 2, 1, 1);
    pulse_req(1'b1, 1'b0);
    tk(6, 2, 1, 3);
    tk(7, 2, 1, 4);
    tk(3, 1, 0, 1);
    // Hit during attack frame 6, restart of the hold at HIT tick 5.
    pulse_req(1'b1, 1'b0);
    tk(5, 2, 1, 4);
    tk(6, 2, 1, 1);
    pulse_req(1'b0, 1'b1);
    tk(8, 3, 1, 5);
    pulse_req(1'b0, 1'b1);
    tk(8, 3, 1, 8);
    tk(3, 1, 0, 1);
    // Simultaneous requests: hit wins, attack discarded, exit to idle.
    pulse_req(1'b1, 1'b1);
    tk(8, 3, 1, 7);
    motionx1 = 10'd0;
    tk(8, 3, 1, 1);
    tk(0, 0, 0, 2);
    // Attack from idle returns to idle with rage evaluated on return.
    healthL = 8'd130;
    pulse_req(1'b1, 1'b0);
    tk(5, 2, 1, 4);
    tk(6, 2, 1, 4);
    tk(7, 2, 1, 4);
    tk(1, 0, 0, 1);

    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge vga_clk);
    n_checks++;
    if (sb_q.size() == 0) pass_cnt++;
    else $display("FAIL drain: got %0d entries left expected 0", sb_q.size());
    $display("%0d/%0d checks passed", pass_cnt, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
